// File: rtl/ccu_snoop_bcast.sv
// Snoop broadcast / response-merge stage.
// Multicasts one upstream AC request to every cache selected by the domain mask,
// ORs the CR responses together, forwards a single CD stream upstream and drains
// any redundant data streams. One snoop transaction is in flight at a time.
//
// Optional feature: define CCU_SNOOP_BCAST_DIRTY_ERR_EN to flag Error in the merged
// response when more than one cache returns PassDirty.
//
// Merged resp bits: [4] WasUnique, [3] IsShared, [2] PassDirty, [1] Error,
// [0] DataTransfer.
module ccu_snoop_bcast #(
  parameter int unsigned NoMstPorts = 4,
  parameter int unsigned AddrWidth  = 32,
  parameter int unsigned DataWidth  = 32
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  // Upstream snoop port (from the CCU snoop path)
  input  logic                            slv_ac_valid_i,
  output logic                            slv_ac_ready_o,
  input  logic [AddrWidth-1:0]            slv_ac_addr_i,
  input  logic [3:0]                      slv_ac_snoop_i,
  input  logic [2:0]                      slv_ac_prot_i,
  output logic                            slv_cr_valid_o,
  input  logic                            slv_cr_ready_i,
  output logic [4:0]                      slv_cr_resp_o,
  output logic                            slv_cd_valid_o,
  input  logic                            slv_cd_ready_i,
  output logic [DataWidth-1:0]            slv_cd_data_o,
  output logic                            slv_cd_last_o,
  // Target caches, sampled with the upstream AC handshake
  input  logic [NoMstPorts-1:0]           domain_mask_i,
  // Downstream snoop ports (one per cache); AC payload is broadcast
  output logic [NoMstPorts-1:0]           mst_ac_valid_o,
  input  logic [NoMstPorts-1:0]           mst_ac_ready_i,
  output logic [AddrWidth-1:0]            mst_ac_addr_o,
  output logic [3:0]                      mst_ac_snoop_o,
  output logic [2:0]                      mst_ac_prot_o,
  input  logic [NoMstPorts-1:0]           mst_cr_valid_i,
  output logic [NoMstPorts-1:0]           mst_cr_ready_o,
  input  logic [NoMstPorts*5-1:0]         mst_cr_resp_i,
  input  logic [NoMstPorts-1:0]           mst_cd_valid_i,
  output logic [NoMstPorts-1:0]           mst_cd_ready_o,
  input  logic [NoMstPorts*DataWidth-1:0] mst_cd_data_i,
  input  logic [NoMstPorts-1:0]           mst_cd_last_i
);

  localparam int unsigned IdxW = (NoMstPorts > 1) ? $clog2(NoMstPorts) : 1;

  typedef enum logic [2:0] {StIdle, StAc, StCr, StResp, StCd} state_e;

  state_e                 state_q;
  logic [AddrWidth-1:0]   ac_addr_q;
  logic [3:0]             ac_snoop_q;
  logic [2:0]             ac_prot_q;
  logic [NoMstPorts-1:0]  ac_pend_q;    // AC handshake still outstanding
  logic [NoMstPorts-1:0]  cr_pend_q;    // CR response still outstanding
  logic [NoMstPorts-1:0]  dt_q;         // ports that reported DataTransfer
  logic [NoMstPorts-1:0]  drain_pend_q; // redundant CD streams not yet at last
  logic [4:0]             resp_q;
  logic [IdxW-1:0]        src_q;
  logic                   src_found_q;
  logic                   src_pend_q;   // source CD stream not yet at last

  logic [NoMstPorts-1:0]  cr_hs;
  logic [NoMstPorts-1:0]  cr_dt;
  logic [4:0]             cr_or;
  logic [IdxW-1:0]        src_sel;
  logic                   src_hit;
  logic [NoMstPorts-1:0]  src_onehot;
  logic                   src_cd_valid;
  logic [DataWidth-1:0]   src_cd_data;
  logic                   src_cd_last;
  logic                   src_last_done;
  logic [NoMstPorts-1:0]  drain_done;
  logic [NoMstPorts-1:0]  ac_left;
  logic [NoMstPorts-1:0]  cr_left;
  logic [NoMstPorts-1:0]  drain_left;
  logic                   err_set;

  // Upstream-facing outputs come straight from state registers.
  assign slv_ac_ready_o = (state_q == StIdle);
  assign slv_cr_valid_o = (state_q == StResp);
  assign slv_cr_resp_o  = resp_q;

  assign mst_ac_addr_o  = ac_addr_q;
  assign mst_ac_snoop_o = ac_snoop_q;
  assign mst_ac_prot_o  = ac_prot_q;
  assign mst_ac_valid_o = ac_pend_q & {NoMstPorts{state_q == StAc}};
  assign mst_cr_ready_o = cr_pend_q & {NoMstPorts{state_q == StCr}};

  // Merge all CR handshakes of this cycle and pick the lowest-index data source.
  always_comb begin
    cr_hs   = mst_cr_valid_i & mst_cr_ready_o;
    cr_or   = '0;
    cr_dt   = '0;
    src_sel = '0;
    src_hit = 1'b0;
    for (int i = 0; i < NoMstPorts; i++) begin
      if (cr_hs[i]) begin
        cr_or    = cr_or | mst_cr_resp_i[i*5 +: 5];
        cr_dt[i] = mst_cr_resp_i[i*5];
        if (mst_cr_resp_i[i*5] && !src_hit) begin
          src_sel = IdxW'(i);
          src_hit = 1'b1;
        end
      end
    end
  end

`ifdef CCU_SNOOP_BCAST_DIRTY_ERR_EN
  logic [1:0] dirty_cnt_q;
  logic [1:0] dirty_cnt_d;

  // Count PassDirty responders, saturating at two.
  always_comb begin
    dirty_cnt_d = dirty_cnt_q;
    for (int i = 0; i < NoMstPorts; i++) begin
      if (cr_hs[i] && mst_cr_resp_i[i*5+2] && (dirty_cnt_d != 2'd2)) begin
        dirty_cnt_d = dirty_cnt_d + 2'd1;
      end
    end
  end

  assign err_set = (dirty_cnt_d == 2'd2);

  // Dirty counter restarts with every new transaction.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dirty_cnt_q <= 2'd0;
    end else if (state_q == StIdle) begin
      dirty_cnt_q <= 2'd0;
    end else begin
      dirty_cnt_q <= dirty_cnt_d;
    end
  end
`else
  assign err_set = 1'b0;
`endif

  // Select the source port's CD channel.
  always_comb begin
    src_onehot   = '0;
    src_cd_valid = 1'b0;
    src_cd_data  = '0;
    src_cd_last  = 1'b0;
    for (int i = 0; i < NoMstPorts; i++) begin
      if (IdxW'(i) == src_q) begin
        src_onehot[i] = 1'b1;
        src_cd_valid  = mst_cd_valid_i[i];
        src_cd_data   = mst_cd_data_i[i*DataWidth +: DataWidth];
        src_cd_last   = mst_cd_last_i[i];
      end
    end
  end

  // Source CD is a combinational pass-through; redundant streams are sunk.
  assign slv_cd_valid_o = (state_q == StCd) && src_pend_q && src_cd_valid;
  assign slv_cd_data_o  = src_cd_data;
  assign slv_cd_last_o  = src_cd_last;

  always_comb begin
    mst_cd_ready_o = drain_pend_q;
    if ((state_q == StCd) && src_pend_q && slv_cd_ready_i) begin
      mst_cd_ready_o = mst_cd_ready_o | src_onehot;
    end
  end

  assign src_last_done = slv_cd_valid_o && slv_cd_ready_i && src_cd_last;
  assign drain_done    = drain_pend_q & mst_cd_valid_i & mst_cd_last_i;
  assign ac_left       = ac_pend_q & ~mst_ac_ready_i;
  assign cr_left       = cr_pend_q & ~cr_hs;
  assign drain_left    = drain_pend_q & ~drain_done;

  // Transaction FSM: broadcast AC, collect CR, respond upstream, stream CD.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      ac_addr_q    <= '0;
      ac_snoop_q   <= '0;
      ac_prot_q    <= '0;
      ac_pend_q    <= '0;
      cr_pend_q    <= '0;
      dt_q         <= '0;
      drain_pend_q <= '0;
      resp_q       <= '0;
      src_q        <= '0;
      src_found_q  <= 1'b0;
      src_pend_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (slv_ac_valid_i) begin
            ac_addr_q    <= slv_ac_addr_i;
            ac_snoop_q   <= slv_ac_snoop_i;
            ac_prot_q    <= slv_ac_prot_i;
            ac_pend_q    <= domain_mask_i;
            cr_pend_q    <= domain_mask_i;
            dt_q         <= '0;
            drain_pend_q <= '0;
            resp_q       <= '0;
            src_q        <= '0;
            src_found_q  <= 1'b0;
            src_pend_q   <= 1'b0;
            state_q      <= (|domain_mask_i) ? StAc : StResp;
          end
        end
        StAc: begin
          ac_pend_q <= ac_left;
          if (ac_left == '0) begin
            state_q <= StCr;
          end
        end
        StCr: begin
          cr_pend_q <= cr_left;
          resp_q    <= resp_q | cr_or | {3'b000, err_set, 1'b0};
          dt_q      <= dt_q | cr_dt;
          if (!src_found_q && src_hit) begin
            src_q       <= src_sel;
            src_found_q <= 1'b1;
          end
          if (cr_left == '0) begin
            state_q <= StResp;
          end
        end
        StResp: begin
          if (slv_cr_ready_i) begin
            if (src_found_q) begin
              src_pend_q   <= 1'b1;
              drain_pend_q <= dt_q & ~src_onehot;
              state_q      <= StCd;
            end else begin
              state_q <= StIdle;
            end
          end
        end
        StCd: begin
          if (src_last_done) begin
            src_pend_q <= 1'b0;
          end
          drain_pend_q <= drain_left;
          if ((src_last_done || !src_pend_q) && (drain_left == '0)) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ccu_snoop_bcast.sv
// Directed bench for ccu_snoop_bcast (4 ports, 32-bit address and data).
module tb_ccu_snoop_bcast;

  localparam int unsigned N  = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic            clk;
  logic            rst_ni;
  logic            slv_ac_valid;
  logic            slv_ac_ready;
  logic [AW-1:0]   slv_ac_addr;
  logic [3:0]      slv_ac_snoop;
  logic [2:0]      slv_ac_prot;
  logic            slv_cr_valid;
  logic            slv_cr_ready;
  logic [4:0]      slv_cr_resp;
  logic            slv_cd_valid;
  logic            slv_cd_ready;
  logic [DW-1:0]   slv_cd_data;
  logic            slv_cd_last;
  logic [N-1:0]    domain_mask;
  logic [N-1:0]    mst_ac_valid;
  logic [N-1:0]    mst_ac_ready;
  logic [AW-1:0]   mst_ac_addr;
  logic [3:0]      mst_ac_snoop;
  logic [2:0]      mst_ac_prot;
  logic [N-1:0]    mst_cr_valid;
  logic [N-1:0]    mst_cr_ready;
  logic [N*5-1:0]  mst_cr_resp;
  logic [N-1:0]    mst_cd_valid;
  logic [N-1:0]    mst_cd_ready;
  logic [N*DW-1:0] mst_cd_data;
  logic [N-1:0]    mst_cd_last;

  int compared   = 0;
  int mismatched = 0;

  ccu_snoop_bcast #(
    .NoMstPorts(N),
    .AddrWidth (AW),
    .DataWidth (DW)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .slv_ac_valid_i  (slv_ac_valid),
    .slv_ac_ready_o  (slv_ac_ready),
    .slv_ac_addr_i   (slv_ac_addr),
    .slv_ac_snoop_i  (slv_ac_snoop),
    .slv_ac_prot_i   (slv_ac_prot),
    .slv_cr_valid_o  (slv_cr_valid),
    .slv_cr_ready_i  (slv_cr_ready),
    .slv_cr_resp_o   (slv_cr_resp),
    .slv_cd_valid_o  (slv_cd_valid),
    .slv_cd_ready_i  (slv_cd_ready),
    .slv_cd_data_o   (slv_cd_data),
    .slv_cd_last_o   (slv_cd_last),
    .domain_mask_i   (domain_mask),
    .mst_ac_valid_o  (mst_ac_valid),
    .mst_ac_ready_i  (mst_ac_ready),
    .mst_ac_addr_o   (mst_ac_addr),
    .mst_ac_snoop_o  (mst_ac_snoop),
    .mst_ac_prot_o   (mst_ac_prot),
    .mst_cr_valid_i  (mst_cr_valid),
    .mst_cr_ready_o  (mst_cr_ready),
    .mst_cr_resp_i   (mst_cr_resp),
    .mst_cd_valid_i  (mst_cd_valid),
    .mst_cd_ready_o  (mst_cd_ready),
    .mst_cd_data_i   (mst_cd_data),
    .mst_cd_last_i   (mst_cd_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    slv_ac_valid = 1'b0;
    slv_ac_addr  = '0;
    slv_ac_snoop = '0;
    slv_ac_prot  = '0;
    slv_cr_ready = 1'b0;
    slv_cd_ready = 1'b0;
    domain_mask  = '0;
    mst_ac_ready = '0;
    mst_cr_valid = '0;
    mst_cr_resp  = '0;
    mst_cd_valid = '0;
    mst_cd_data  = '0;
    mst_cd_last  = '0;
  endtask

  // One-cycle upstream AC; returns at the falling edge of the cycle after acceptance.
  task automatic send_ac(input logic [AW-1:0] addr, input logic [N-1:0] mask);
    slv_ac_valid = 1'b1;
    slv_ac_addr  = addr;
    slv_ac_snoop = 4'h7;
    slv_ac_prot  = 3'h2;
    domain_mask  = mask;
    chk("ac_ready_idle", 64'(slv_ac_ready), 64'd1);
    cyc();
    slv_ac_valid = 1'b0;
    domain_mask  = '0;
  endtask

  // Upstream CR handshake from RESP.
  task automatic take_cr();
    slv_cr_ready = 1'b1;
    cyc();
    slv_cr_ready = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst_ni = 1'b0;
    cyc();
    cyc();
    // Reset state
    chk("rst_ac_ready", 64'(slv_ac_ready), 64'd1);
    chk("rst_cr_valid", 64'(slv_cr_valid), 64'd0);
    chk("rst_cd_valid", 64'(slv_cd_valid), 64'd0);
    chk("rst_mst_ac_valid", 64'(mst_ac_valid), 64'd0);
    chk("rst_mst_cr_ready", 64'(mst_cr_ready), 64'd0);
    chk("rst_mst_cd_ready", 64'(mst_cd_ready), 64'd0);
    chk("rst_resp", 64'(slv_cr_resp), 64'd0);
    rst_ni = 1'b1;
    cyc();

    // Zero mask: immediate empty response, nothing sent downstream.
    send_ac(32'h1000, 4'b0000);
    chk("z_mst_ac_valid", 64'(mst_ac_valid), 64'd0);
    chk("z_cr_valid", 64'(slv_cr_valid), 64'd1);
    chk("z_resp", 64'(slv_cr_resp), 64'd0);
    chk("z_ac_ready", 64'(slv_ac_ready), 64'd0);
    take_cr();
    chk("z_idle_ac_ready", 64'(slv_ac_ready), 64'd1);
    chk("z_no_cd", 64'(slv_cd_valid), 64'd0);

    // Mask 0101: merged 01001, source port2 streams 4 beats.
    send_ac(32'h2000, 4'b0101);
    chk("m5_ac_valid", 64'(mst_ac_valid), 64'b0101);
    chk("m5_ac_addr", 64'(mst_ac_addr), 64'h2000);
    chk("m5_ac_snoop", 64'(mst_ac_snoop), 64'h7);
    chk("m5_ac_prot", 64'(mst_ac_prot), 64'h2);
    mst_ac_ready = 4'b0101;
    cyc();
    mst_ac_ready = '0;
    chk("m5_ac_valid_done", 64'(mst_ac_valid), 64'd0);
    chk("m5_cr_ready", 64'(mst_cr_ready), 64'b0101);
    mst_cr_valid = 4'b0101;
    mst_cr_resp[0 +: 5]  = 5'b01000;
    mst_cr_resp[10 +: 5] = 5'b00001;
    cyc();
    mst_cr_valid = '0;
    mst_cr_resp  = '0;
    chk("m5_cr_valid", 64'(slv_cr_valid), 64'd1);
    chk("m5_resp", 64'(slv_cr_resp), 64'b01001);
    take_cr();
    chk("m5_cd_valid_idle", 64'(slv_cd_valid), 64'd0);
    chk("m5_cd_ready_noslv", 64'(mst_cd_ready), 64'd0);
    slv_cd_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      mst_cd_valid[2]          = 1'b1;
      mst_cd_data[2*DW +: DW]  = 32'hA0 + 32'(b);
      mst_cd_last[2]           = (b == 3);
      #1;
      chk("m5_cd_valid", 64'(slv_cd_valid), 64'd1);
      chk("m5_cd_data", 64'(slv_cd_data), 64'hA0 + 64'(b));
      chk("m5_cd_last", 64'(slv_cd_last), 64'(b == 3));
      chk("m5_cd_ready", 64'(mst_cd_ready), 64'b0100);
      cyc();
    end
    mst_cd_valid = '0;
    mst_cd_last  = '0;
    slv_cd_ready = 1'b0;
    chk("m5_back_idle", 64'(slv_ac_ready), 64'd1);

    // Mask 1111: ports 1 and 3 carry data; port1 is source, port3 is drained.
    send_ac(32'h3000, 4'b1111);
    mst_ac_ready = 4'b1111;
    cyc();
    mst_ac_ready = '0;
    mst_cr_valid = 4'b1111;
    mst_cr_resp[5 +: 5]  = 5'b00001;
    mst_cr_resp[10 +: 5] = 5'b01000;
    mst_cr_resp[15 +: 5] = 5'b00001;
    mst_cd_valid[3] = 1'b1;  // port3 data shows up early
    mst_cd_data[3*DW +: DW] = 32'hDEAD;
    #1;
    chk("mf_cd_ready_in_cr", 64'(mst_cd_ready), 64'd0);
    cyc();
    mst_cr_valid = '0;
    mst_cr_resp  = '0;
    chk("mf_resp", 64'(slv_cr_resp), 64'b01001);
    chk("mf_cd_ready_in_resp", 64'(mst_cd_ready), 64'd0);
    take_cr();
    chk("mf_drain_ready", 64'(mst_cd_ready), 64'b1000);
    chk("mf_no_fwd_drain", 64'(slv_cd_valid), 64'd0);
    cyc();  // port3 beat 0 drained
    mst_cd_valid[3] = 1'b0;
    slv_cd_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      mst_cd_valid[1]         = 1'b1;
      mst_cd_data[1*DW +: DW] = 32'hB0 + 32'(b);
      mst_cd_last[1]          = (b == 1);
      #1;
      chk("mf_cd_data", 64'(slv_cd_data), 64'hB0 + 64'(b));
      chk("mf_cd_ready", 64'(mst_cd_ready), 64'b1010);
      cyc();
    end
    mst_cd_valid = '0;
    mst_cd_last  = '0;
    slv_cd_ready = 1'b0;
    chk("mf_wait_drain", 64'(slv_ac_ready), 64'd0);
    chk("mf_drain_still", 64'(mst_cd_ready), 64'b1000);
    mst_cd_valid[3] = 1'b1;
    mst_cd_last[3]  = 1'b1;
    cyc();
    mst_cd_valid = '0;
    mst_cd_last  = '0;
    mst_cd_data  = '0;
    chk("mf_back_idle", 64'(slv_ac_ready), 64'd1);

    // Staggered AC ready: port0 at +1, port3 at +5; second AC held meanwhile.
    send_ac(32'h4000, 4'b1001);
    slv_ac_valid = 1'b1;
    slv_ac_addr  = 32'h5000;
    domain_mask  = 4'b0000;
    mst_ac_ready[0] = 1'b1;
    mst_cr_valid[0] = 1'b1;  // early CR must wait for all ACs
    chk("st_ac_valid_both", 64'(mst_ac_valid), 64'b1001);
    chk("st_ac_stalled", 64'(slv_ac_ready), 64'd0);
    cyc();
    mst_ac_ready = '0;
    for (int k = 0; k < 4; k++) begin
      chk("st_ac_valid_p3", 64'(mst_ac_valid), 64'b1000);
      chk("st_no_cr", 64'(mst_cr_ready), 64'd0);
      cyc();
    end
    mst_ac_ready[3] = 1'b1;
    cyc();
    mst_ac_ready = '0;
    chk("st_cr_ready", 64'(mst_cr_ready), 64'b1001);
    mst_cr_valid[3] = 1'b1;
    mst_cr_resp[15 +: 5] = 5'b10000;
    cyc();
    mst_cr_valid = '0;
    mst_cr_resp  = '0;
    chk("st_resp", 64'(slv_cr_resp), 64'b10000);
    chk("st_ac_still_stalled", 64'(slv_ac_ready), 64'd0);
    take_cr();
    chk("st_ac_ready_idle", 64'(slv_ac_ready), 64'd1);
    cyc();  // queued AC (zero mask) accepted
    slv_ac_valid = 1'b0;
    domain_mask  = '0;
    chk("st2_cr_valid", 64'(slv_cr_valid), 64'd1);
    chk("st2_resp", 64'(slv_cr_resp), 64'd0);
    take_cr();

    // Two PassDirty responders.
    send_ac(32'h6000, 4'b0011);
    mst_ac_ready = 4'b0011;
    cyc();
    mst_ac_ready = '0;
    mst_cr_valid = 4'b0011;
    mst_cr_resp[0 +: 5] = 5'b00100;
    mst_cr_resp[5 +: 5] = 5'b00100;
    cyc();
    mst_cr_valid = '0;
    mst_cr_resp  = '0;
`ifdef CCU_SNOOP_BCAST_DIRTY_ERR_EN
    chk("dirty_resp", 64'(slv_cr_resp), 64'b00110);
`else
    chk("dirty_resp", 64'(slv_cr_resp), 64'b00100);
`endif
    take_cr();
    chk("dirty_idle", 64'(slv_ac_ready), 64'd1);

    // Reset pulled during CD.
    send_ac(32'h7000, 4'b0001);
    mst_ac_ready = 4'b0001;
    cyc();
    mst_ac_ready = '0;
    mst_cr_valid[0] = 1'b1;
    mst_cr_resp[0 +: 5] = 5'b00001;
    cyc();
    mst_cr_valid = '0;
    mst_cr_resp  = '0;
    take_cr();
    slv_cd_ready    = 1'b1;
    mst_cd_valid[0] = 1'b1;
    mst_cd_data[0 +: DW] = 32'hC0;
    #1;
    chk("rcd_cd_valid", 64'(slv_cd_valid), 64'd1);
    chk("rcd_cd_ready", 64'(mst_cd_ready), 64'b0001);
    rst_ni = 1'b0;
    #1;
    chk("rcd_cd_valid_rst", 64'(slv_cd_valid), 64'd0);
    chk("rcd_cd_ready_rst", 64'(mst_cd_ready), 64'd0);
    chk("rcd_ac_ready_rst", 64'(slv_ac_ready), 64'd1);
    chk("rcd_cr_valid_rst", 64'(slv_cr_valid), 64'd0);
    chk("rcd_resp_rst", 64'(slv_cr_resp), 64'd0);
    clear_inputs();
    cyc();
    rst_ni = 1'b1;
    cyc();
    send_ac(32'h8000, 4'b0010);
    chk("post_ac_valid", 64'(mst_ac_valid), 64'b0010);
    chk("post_ac_addr", 64'(mst_ac_addr), 64'h8000);
    mst_ac_ready = 4'b0010;
    cyc();
    mst_ac_ready = '0;
    mst_cr_valid[1] = 1'b1;
    mst_cr_resp[5 +: 5] = 5'b10000;
    cyc();
    mst_cr_valid = '0;
    mst_cr_resp  = '0;
    chk("post_resp", 64'(slv_cr_resp), 64'b10000);
    take_cr();
    chk("post_idle", 64'(slv_ac_ready), 64'd1);
    chk("post_no_cd", 64'(slv_cd_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ccu_snoop_bcast.md
# ccu_snoop_bcast

Snoop broadcast and response-merge stage that sits directly downstream of the CCU snoop path. It takes one snoop port (AC/CR/CD) together with its domain mask and multicasts the AC request to every selected cached master. It collects and merges the CR responses, forwards exactly one CD data stream upstream, and drains any redundant data. One instance is used per snoop port: one for the write path and one for the read path.

## Interface
Parameters:
- NoMstPorts, 4, number of snooped caches; must be ≥ 1.
- snoop_req_t, logic, snoop port request type (ac, ac_valid, cr_ready, cd_ready).
- snoop_resp_t, logic, snoop port response type (ac_ready, cr_valid, cr_resp, cd_valid, cd{data,last}).
- domain_mask_t, logic, `logic [NoMstPorts-1:0]`; one bit per master port.

Ports:
- clk_i  in  1  clock; all logic rising-edge.
- rst_ni  in  1  asynchronous active-low reset.
- slv_snoop_req_i  in  snoop_req_t  snoop request from the CCU snoop path.
- slv_snoop_resp_o  out  snoop_resp_t  merged response to the CCU snoop path.
- domain_mask_i  in  NoMstPorts  target ports; sampled with the AC handshake.
- mst_snoop_reqs_o  out  [NoMstPorts-1:0] snoop_req_t  per-cache snoop requests.
- mst_snoop_resps_i  in  [NoMstPorts-1:0] snoop_resp_t  per-cache snoop responses.

## Operation
- One snoop transaction is in flight at a time. The FSM states are IDLE, AC, CR, RESP, CD.
- IDLE:
  - slv ac_ready=1.
  - On slv ac_valid&ac_ready, register the ac payload and mask; clear the per-port pending vectors.
  - Mask nonzero → AC. Mask zero → RESP with a merged resp of 0.
- AC:
  - Assert mst ac_valid[i] for each masked i whose AC handshake has not yet completed. Drop each one individually on its handshake.
  - Once all masked ports have handshaked → CR.
- CR:
  - cr_ready[i]=1 for masked ports that are still pending.
  - On each handshake, OR the port's cr_resp into the merged register.
  - The first port, lowest index among those accepted in the same cycle, with DataTransfer (bit0)=1 becomes the data source.
  - Once all CRs are collected → RESP.
- RESP:
  - slv cr_valid=1 with the merged resp, held stable until cr_ready.
  - On handshake → CD if any port reported DataTransfer, otherwise → IDLE.
- CD:
  - The source port's cd_valid/cd is passed combinationally to slv cd; the source cd_ready equals slv cd_ready.
  - Every other port that reported DataTransfer gets cd_ready=1, and its beats are discarded until its last.
  - Leave CD for IDLE when the source last beat has handshaked AND all drain ports have delivered last.
- Merged resp bits: WasUnique[4], IsShared[3], PassDirty[2], Error[1], DataTransfer[0]. Each bit is the OR over the responding ports.
- CD beats arriving before CD state are not accepted: cd_ready=0 outside CD.

## Timing
- Reset values:
  - state=IDLE.
  - All mst ac_valid, cr_ready and cd_ready = 0.
  - slv cr_valid=0, cd_valid=0, ac_ready=1.
  - Merged resp=0; pending vectors=0.
- AC latency: the slv AC handshake is in cycle N, and the earliest mst ac_valid is in cycle N+1.
- An upstream AC cannot be accepted in the same cycle that CD or RESP exits to IDLE. The next earliest AC acceptance is the following cycle.
- Zero mask: slv cr_valid is asserted at N+1 with resp=0.
- A CR may arrive in the same cycle as another port's CR or AC handshake; every simultaneous handshake is captured.
- Valid signals never depend combinationally on the matching ready, except the CD pass-through of the source port.
- Asynchronous reset mid-transaction aborts the transaction and returns all outputs to their reset values immediately.

## Configuration
- CCU_SNOOP_BCAST_DIRTY_ERR_EN:
  - Defined: if more than one port reports PassDirty=1, the merged resp gets Error=1. A counter records the number of PassDirty responders; it saturates at 2.
  - Undefined: PassDirty and Error are plain ORs, with no multi-dirty detection logic.

## Test plan
- Zero-mask AC with ac.addr=0x1000 → no mst ac_valid; slv cr_resp=5'b00000 one cycle after the AC handshake; no CD.
- Mask=4'b0101; port0 cr_resp=5'b01000 and port2 cr_resp=5'b00001 → merged 5'b01001; CD from port2 forwarded (4 beats, last on beat 4); port0 gets no cd_ready.
- Mask=4'b1111; ports 1 and 3 both report DataTransfer; port3's CD arrives first → port1 is the source and port3's data is drained. Return to IDLE only after both lasts.
- Staggered ac_ready: port0 acks at +1 cycle and port3 at +5 → ac_valid[0] drops after its handshake; no CR is accepted before all ACs complete; a second upstream AC is stalled until IDLE.
- With CCU_SNOOP_BCAST_DIRTY_ERR_EN, two ports return PassDirty → merged Error=1. Without the macro → Error=0 and PassDirty=1.
- rst_ni pulled low while in CD → all valids and readys reach reset values in the same cycle; afterwards a new AC completes normally.
